// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_pkg                                                        |
// | Brief    : Shared UART state encoding, bit-period and parity helpers.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic logic par(input logic [DATA_BITS-1:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_baud_cnt                                                   |
// | Brief    : Bit-period counter, 0..CLKS_PER_BIT-1, with clear and tick.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Terminal count restarts the period, so the counter never passes CLKS_PER_BIT-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == TERMINAL) && !clear;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx                                                         |
// | Brief    : UART serialiser, 8 data bits, optional parity, 1 or 2 stops.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);

  generate
    if (CLKS_PER_BIT < 2) begin : g_chk_clks
      $error("uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_e          r_state, w_state;
  logic [DATA_BITS-1:0] r_data,  w_data;
  logic [2:0]           r_idx,   w_idx;
  logic                 r_stop,  w_stop;
  logic                 r_tx,    w_tx;
  logic                 r_ready, w_ready;
  logic                 r_busy,  w_busy;
  logic                 w_tick;
  logic [2:0]           w_idx_inc;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(r_state == IDLE),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_idx   <= '0;
      r_stop  <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_idx   <= w_idx;
      r_stop  <= w_stop;
      r_tx    <= w_tx;
      r_ready <= w_ready;
      r_busy  <= w_busy;
    end
  end

  assign w_idx_inc = r_idx + 3'd1;

  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_idx   = r_idx;
    w_stop  = r_stop;
    w_tx    = r_tx;
    w_ready = r_ready;
    w_busy  = r_busy;
    case (r_state)
      IDLE: begin
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_ready = 1'b1;
        if (tx_valid && r_ready) begin
          w_state = START;
          w_data  = tx_data;
          w_idx   = 3'd0;
          w_stop  = 1'b0;
          w_tx    = 1'b0;
          w_ready = 1'b0;
          w_busy  = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_state = DATA;
          w_idx   = 3'd0;
          w_tx    = r_data[0];
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              w_state = PARITY;
              w_tx    = par(r_data, PARITY_ODD != 0);
            end else begin
              w_state = STOP;
              w_stop  = 1'b0;
              w_tx    = 1'b1;
            end
          end else begin
            w_idx = w_idx_inc;
            w_tx  = r_data[w_idx_inc];
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state = STOP;
          w_stop  = 1'b0;
          w_tx    = 1'b1;
        end
      end
      STOP: begin
        w_tx = 1'b1;
        if (w_tick) begin
          if ((STOP_BITS == 2) && !r_stop) begin
            w_stop = 1'b1;
          end else begin
            // Ready only becomes visible next edge: one idle clk between frames.
            w_state = IDLE;
            w_busy  = 1'b0;
            w_ready = 1'b1;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_ready = 1'b0;
      end
    endcase
  end

  assign tx_ready = r_ready;
  assign tx       = r_tx;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx                                                      |
// | Brief    : Directed bench for uart_tx at 16 clks/bit (8N1, 8E2, 8O2).      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_d [3];
  logic [2:0] valid_d;
  logic [2:0] ready_w;
  logic [2:0] tx_w;
  logic [2:0] busy_w;

  int n_cmp = 0;
  int n_err = 0;

  logic obs_tx   [0:399];
  logic obs_rdy  [0:399];
  logic obs_busy [0:399];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(data_d[0]), .tx_valid(valid_d[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

  uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_8e2 (
    .clk(clk), .rst(rst), .tx_data(data_d[1]), .tx_valid(valid_d[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

  uart_tx #(.BAUD_RATE(1), .CLOCK_FREQ(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_8o2 (
    .clk(clk), .rst(rst), .tx_data(data_d[2]), .tx_valid(valid_d[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  // Sample index i holds the outputs 1 time unit after the i-th edge from the call.
  task automatic record(input int w, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs_tx[start+i]   = tx_w[w];
      obs_rdy[start+i]  = ready_w[w];
      obs_busy[start+i] = busy_w[w];
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid_d = 3'b000;
    for (int i = 0; i < 3; i++) data_d[i] = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({tx_w, ready_w, busy_w} !== {3'b111, 3'b000, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: tx/ready/busy=%b/%b/%b required 111/000/000", tx_w, ready_w, busy_w);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ready_w !== 3'b111) begin
      n_err++;
      $display("FAIL ready_after_release: ready=%b required 111", ready_w);
    end
  endtask

  task automatic test_frame_8n1();
    logic [9:0] exp_bits;
    int bad;
    exp_bits = 10'b1_1010_0101_0;
    data_d[0] = 8'hA5;
    valid_d[0] = 1'b1;
    record(0, 0, 1);
    valid_d[0] = 1'b0;
    data_d[0] = 8'h00;
    record(0, 1, 170);
    n_cmp++;
    if (obs_busy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL a5_busy_on_accept: busy=%b required 1", obs_busy[0]);
    end
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int k = 0; k < 16; k++) if (obs_tx[b*16+k] !== exp_bits[b]) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL a5_bit%0d: %0d of 16 clks differ from required level %b", b, bad, exp_bits[b]);
      end
    end
    bad = 0;
    for (int k = 0; k < 160; k++) if (obs_rdy[k] !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL a5_ready_low: ready high on %0d of 160 clks, required 0", bad);
    end
    n_cmp++;
    if ({obs_rdy[160], obs_busy[160], obs_tx[160]} !== 3'b101) begin
      n_err++;
      $display("FAIL a5_frame_end: ready/busy/tx=%b%b%b required 101", obs_rdy[160], obs_busy[160], obs_tx[160]);
    end
  endtask

  task automatic test_parity_stop2();
    logic [11:0] exp_bits;
    int bad;
    for (int w = 1; w < 3; w++) begin
      exp_bits = (w == 1) ? 12'b11_1_0000_0111_0 : 12'b11_0_0000_0111_0;
      data_d[w] = 8'h07;
      valid_d[w] = 1'b1;
      record(w, 0, 1);
      valid_d[w] = 1'b0;
      record(w, 1, 199);
      for (int b = 0; b < 12; b++) begin
        bad = 0;
        for (int k = 0; k < 16; k++) if (obs_tx[b*16+k] !== exp_bits[b]) bad++;
        n_cmp++;
        if (bad != 0) begin
          n_err++;
          $display("FAIL par%0d_bit%0d: %0d of 16 clks differ from required level %b", w, b, bad, exp_bits[b]);
        end
      end
      n_cmp++;
      if ({obs_rdy[191], obs_rdy[192], obs_busy[192]} !== 3'b010) begin
        n_err++;
        $display("FAIL par%0d_frame_end: ready@191/ready@192/busy@192=%b%b%b required 010",
                 w, obs_rdy[191], obs_rdy[192], obs_busy[192]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got1, got2;
    int bad;
    data_d[0] = 8'h55;
    valid_d[0] = 1'b1;
    record(0, 0, 1);
    data_d[0] = 8'hAA;
    record(0, 1, 161);
    valid_d[0] = 1'b0;
    record(0, 162, 180);
    n_cmp++;
    if ({obs_tx[159], obs_tx[160], obs_tx[161], obs_rdy[160], obs_rdy[161]} !== 5'b11010) begin
      n_err++;
      $display("FAIL b2b_gap: tx@159..161=%b%b%b ready@160,161=%b%b required 110 10",
               obs_tx[159], obs_tx[160], obs_tx[161], obs_rdy[160], obs_rdy[161]);
    end
    for (int i = 0; i < 8; i++) begin
      got1[i] = obs_tx[16*(i+1)+8];
      got2[i] = obs_tx[161+16*(i+1)+8];
    end
    n_cmp++;
    if (got1 !== 8'h55) begin
      n_err++;
      $display("FAIL b2b_byte1: got %h required 55", got1);
    end
    n_cmp++;
    if (got2 !== 8'hAA) begin
      n_err++;
      $display("FAIL b2b_byte2: got %h required aa", got2);
    end
    bad = 0;
    for (int k = 305; k < 342; k++) if (obs_tx[k] !== 1'b1) bad++;
    n_cmp++;
    if (bad != 0 || obs_rdy[321] !== 1'b1 || obs_rdy[320] !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_tail: %0d low clks after stop, ready@320,321=%b%b required 0 and 01",
               bad, obs_rdy[320], obs_rdy[321]);
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] exp_bits;
    logic [7:0] got;
    int bad;
    data_d[0] = 8'hF0;
    valid_d[0] = 1'b1;
    record(0, 0, 1);
    valid_d[0] = 1'b0;
    record(0, 1, 69);
    n_cmp++;
    if (obs_tx[69] !== 1'b0) begin
      n_err++;
      $display("FAIL f0_d3_level: tx=%b required 0", obs_tx[69]);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({tx_w[0], ready_w[0], busy_w[0]} !== 3'b100) begin
      n_err++;
      $display("FAIL async_abort: tx/ready/busy=%b%b%b required 100", tx_w[0], ready_w[0], busy_w[0]);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    record(0, 0, 200);
    bad = 0;
    for (int k = 0; k < 200; k++) if (obs_tx[k] !== 1'b1 || obs_busy[k] !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0 || obs_rdy[0] !== 1'b1) begin
      n_err++;
      $display("FAIL no_residual: %0d clks with tx low or busy, ready@0=%b required 0 and 1", bad, obs_rdy[0]);
    end
    exp_bits = 10'b1_0011_1100_0;
    data_d[0] = 8'h3C;
    valid_d[0] = 1'b1;
    record(0, 0, 1);
    valid_d[0] = 1'b0;
    record(0, 1, 165);
    bad = 0;
    for (int k = 0; k < 160; k++) if (obs_tx[k] !== exp_bits[k/16]) bad++;
    for (int i = 0; i < 8; i++) got[i] = obs_tx[16*(i+1)+8];
    n_cmp++;
    if (bad != 0 || got !== 8'h3C) begin
      n_err++;
      $display("FAIL post_reset_3c: byte %h with %0d wrong clks, required 3c with 0", got, bad);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [9:0] exp_bits;
    int bad;
    exp_bits = 10'b1_0001_0010_0;
    data_d[0] = 8'h12;
    valid_d[0] = 1'b1;
    record(0, 0, 1);
    valid_d[0] = 1'b0;
    record(0, 1, 49);
    data_d[0] = 8'hFF;
    valid_d[0] = 1'b1;
    record(0, 50, 1);
    valid_d[0] = 1'b0;
    record(0, 51, 170);
    bad = 0;
    for (int k = 0; k < 160; k++) if (obs_tx[k] !== exp_bits[k/16]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ignore_frame: %0d clks differ from frame 12, required 0", bad);
    end
    bad = 0;
    for (int k = 160; k < 221; k++) if (obs_tx[k] !== 1'b1 || obs_busy[k] !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ignore_no_second: %0d idle clks with tx low or busy, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity_stop2();
    test_back_to_back();
    test_reset_midframe();
    test_ignore_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
